// File: rtl/pb_load_pkg.sv
// pb_load_pkg: shared slot count, default parameters and slot index type for the button front end.
package pb_load_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_DATA_W = 4;
  typedef logic [1:0] slot_idx_t;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: two-flop synchroniser, stable-count debouncer and rising-edge pulse for one button.
module pb_debounce
  import pb_load_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, pb_s, level_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      pb_s <= 1'b0;
      level <= 1'b0;
      level_d <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= pb;
      pb_s <= s1;
      level_d <= level;
      if (pb_s == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= pb_s;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  // High for the single cycle after level rises; the top registers it into load_pulse.
  assign rise = level & ~level_d;
endmodule

// File: rtl/pb_load_debouncer.sv
// pb_load_debouncer: debounced button loads of holder into four operand slots.
// Define PB_HOLDER_SYNC_EN to pass holder through a two-flop synchroniser before capture.
module pb_load_debouncer
  import pb_load_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SLOTS-1:0]          pb,
  input  logic [DATA_W-1:0]             holder,
  output logic [NUM_SLOTS*DATA_W-1:0]   nums,
  output logic [NUM_SLOTS-1:0]          load_pulse,
  output logic                          any_load,
  output logic [NUM_SLOTS-1:0]          pb_level
);
  logic [NUM_SLOTS-1:0] rise;
  logic [DATA_W-1:0] holder_cap;
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_btn
    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .pb(pb[i]),
      .level(pb_level[i]),
      .rise(rise[i])
    );
  end
`ifdef PB_HOLDER_SYNC_EN
  logic [DATA_W-1:0] h1, h2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= '0;
      h2 <= '0;
    end else begin
      h1 <= holder;
      h2 <= h1;
    end
  end
  assign holder_cap = h2;
`else
  assign holder_cap = holder;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nums <= '0;
      load_pulse <= '0;
    end else begin
      load_pulse <= rise;
      for (int k = 0; k < NUM_SLOTS; k++)
        if (rise[k]) nums[k*DATA_W +: DATA_W] <= holder_cap;
    end
  end
  assign any_load = |load_pulse;
endmodule

// File: tb/tb_pb_load_debouncer.sv
// tb_pb_load_debouncer: directed and random button stimulus checked every cycle against a behavioural model.
module tb_pb_load_debouncer;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] pb = '0;
  logic [3:0] holder = '0;
  logic [15:0] nums;
  logic [3:0] load_pulse, pb_level;
  logic any_load;
  int tests = 0, fails = 0;

  pb_load_debouncer #(.DEBOUNCE_CYCLES(D), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pb(pb), .holder(holder),
    .nums(nums), .load_pulse(load_pulse), .any_load(any_load), .pb_level(pb_level)
  );

  always #5 clk = ~clk;

  // Model: a button level flips once the synchronised input (pb two edges old)
  // has disagreed with it for D consecutive edges; a rise loads on the following edge.
  logic [3:0] p1, p2, hh1, hh2;
  logic [3:0] m_lvl, m_rose, m_pulse;
  logic [15:0] m_nums;
  int run [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    p1 = '0; p2 = '0; hh1 = '0; hh2 = '0;
    m_lvl = '0; m_rose = '0; m_pulse = '0; m_nums = '0;
    for (int i = 0; i < 4; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] cap;
`ifdef PB_HOLDER_SYNC_EN
    cap = hh2;
`else
    cap = holder;
`endif
    m_pulse = m_rose;
    for (int i = 0; i < 4; i++) begin
      if (m_rose[i]) m_nums[i*4 +: 4] = cap;
      m_rose[i] = 1'b0;
      if (p2[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == D) begin
          m_lvl[i] = p2[i];
          m_rose[i] = p2[i];
          run[i] = 0;
        end
      end else run[i] = 0;
    end
    p2 = p1; p1 = pb;
    hh2 = hh1; hh1 = holder;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("pb_level", 32'(pb_level), 32'(m_lvl));
    chk("load_pulse", 32'(load_pulse), 32'(m_pulse));
    chk("any_load", 32'(any_load), 32'(|m_pulse));
    chk("nums", 32'(nums), 32'(m_nums));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt, first;
    model_reset();
    // Reset held with all buttons pressed
    pb = 4'hF;
    holder = 4'hA;
    ticks(5);
    chk("rst_nums", 32'(nums), 0);
    pb = '0;
    ticks(3);
    rst_n = 1'b1;
    ticks(3);
    // Single load with latency and no auto-repeat
    holder = 4'h7;
    pb[0] = 1'b1;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (load_pulse[0]) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("single_cnt", 32'(cnt), 1);
    chk("single_lat", 32'(first), D + 3);
    chk("single_slots", 32'(nums), 32'h0007);
    // Glitches shorter than D on button 1
    pb[1] = 1'b1; ticks(3);
    pb[1] = 1'b0; ticks(2);
    pb[1] = 1'b1; ticks(3);
    pb[1] = 1'b0; ticks(10);
    chk("glitch_level", 32'(pb_level[1]), 0);
    chk("glitch_slot", 32'(nums[7:4]), 0);
    // Simultaneous load of slots 2 and 3
    holder = 4'h3;
    pb[3:2] = 2'b11;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_pulse[3:2] != 2'b00) begin
        cnt++;
        chk("simul_pulse", 32'(load_pulse), 32'b1100);
      end
    end
    chk("simul_cnt", 32'(cnt), 1);
    chk("simul_slots", 32'(nums[15:8]), 32'h33);
    pb = '0; ticks(10);
    // Reload and release on slot 0
    holder = 4'h5; pb[0] = 1'b1; ticks(10);
    chk("reload_a", 32'(nums[3:0]), 5);
    pb[0] = 1'b0; ticks(10);
    holder = 4'h9; pb[0] = 1'b1; ticks(10);
    chk("reload_b", 32'(nums[3:0]), 9);
    pb[0] = 1'b0; ticks(10);
    // Reset in the middle of a debounce count
    holder = 4'hC;
    pb[0] = 1'b1; ticks(4);
    rst_n = 1'b0;
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (load_pulse[0]) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("midrst_cnt", 32'(cnt), 1);
    chk("midrst_lat", 32'(first), D + 3);
    chk("midrst_slot", 32'(nums), 32'h000C);
    // Random segments
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 3) == 0) pb = pb ^ 4'($urandom_range(1, 15));
      holder = 4'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        model_reset();
        ticks(1);
        rst_n = 1'b1;
      end
      ticks($urandom_range(1, 9));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pb_load_debouncer.md
# pb_load_debouncer

Upstream front end for the smallest-of-four display top: it takes the four raw mechanical push buttons and the 4-bit `holder` switch bus, and produces clean, debounced load events and the four captured operands. Each button is synchronised, debounced and edge-detected independently. A qualified press copies `holder` into that button's slot and emits a one-cycle load pulse. Downstream logic consumes `nums` and `load_pulse` directly, so it never clocks registers off button edges.

## Interface
- `DEBOUNCE_CYCLES`, 500000 — stable cycles required before a button level is accepted (10 ms at 50 MHz); legal range ≥ 1.
- `DATA_W`, 4 — operand width.
- `clk` in 1 — single system clock; all state on rising edge.
- `rst_n` in 1 — reset, asynchronous assert, active-low.
- `pb` in 4 — raw push buttons, `pb[i]` is button i+1, active-high, asynchronous to `clk`.
- `holder` in DATA_W — operand switches.
- `nums` out 4*DATA_W — captured slots, slot i at `nums[i*DATA_W +: DATA_W]`.
- `load_pulse` out 4 — `load_pulse[i]` is high for one cycle when slot i is written.
- `any_load` out 1 — OR of `load_pulse`, same cycle.
- `pb_level` out 4 — debounced button levels.

## Operation
- Per button, three stages:
  - Synchroniser: two-flop, giving `pb_s[i]`.
  - Debouncer: counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`, plus stable level `pb_level[i]`.
  - Rising-edge detect on `pb_level[i]`.
- Debounce rules, per edge:
  - If `pb_s == pb_level`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, `pb_level <= pb_s` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles resets the counter and is never accepted.
- Rising edge of `pb_level[i]`: on the next edge, `load_pulse[i] <= 1` and slot i `<= holder`. The slot value is visible in the same cycle as the pulse.
- Falling edge of `pb_level[i]`: no pulse, slot unchanged.
- A held button produces exactly one pulse, with no auto-repeat.
- Buttons are fully independent. Simultaneous qualified presses load all affected slots from the same `holder` sample in the same cycle, with multiple `load_pulse` bits high.
- A slot holds its value indefinitely until its next qualified press.

## Timing
- Reset values: `nums` = 0, `load_pulse` = 0, `any_load` = 0, `pb_level` = 0, all counters and synchroniser flops 0.
- Latency: call the first edge that samples `pb` high edge 1. `pb_level` rises after edge `DEBOUNCE_CYCLES+2`. `load_pulse` and the new slot value appear after edge `DEBOUNCE_CYCLES+3`. This holds provided `pb` stays high throughout.
- Release latency: `pb_level` falls after edge `DEBOUNCE_CYCLES+2`, counting from the first edge that samples `pb` low.
- Capture point: `holder` is sampled at the pulse edge (no synchroniser by default).
- Reset mid-debounce aborts the count.
- A button still held when reset deasserts re-qualifies from zero and generates a fresh load.
- `DEBOUNCE_CYCLES = 1`: a level is accepted after one differing synchronised sample.

## Configuration
- `PB_HOLDER_SYNC_EN`
  - Defined: `holder` passes through a two-flop synchroniser (reset 0) before capture. The loaded value is `holder` as sampled two edges before the pulse edge.
  - Undefined: `holder` is captured directly at the pulse edge.
  - Latency of `load_pulse` is identical either way.

## Structure
- Shared package `pb_load_pkg`:
  - `NUM_SLOTS` = 4.
  - Default `DEBOUNCE_CYCLES` and `DATA_W`.
  - A slot-index typedef (2-bit) reused by the min-index logic downstream.
- Sub-module `pb_debounce` contains the synchroniser, counter, level and rise-pulse output, parameterised by `DEBOUNCE_CYCLES`. The top instantiates four copies, plus the slot registers and the `holder` path.

## Test plan
Run with `DEBOUNCE_CYCLES=4`.
- Reset check: assert `rst_n`=0 with `pb`=4'hF → `nums`=0, `load_pulse`=0, `pb_level`=0 throughout reset.
- Single load: `holder`=4'h7, raise `pb[0]` and hold → `load_pulse`=4'b0001 for exactly one cycle, 7 edges after first sample; slot 0 = 7, other slots = 0; still one pulse after 50 more held cycles.
- Glitch rejection: `pb[1]` high 3 cycles, low, then high 3 cycles → no pulse, `pb_level[1]` stays 0, slot 1 unchanged.
- Simultaneous load: `holder`=4'h3, raise `pb[2]` and `pb[3]` on the same cycle → `load_pulse`=4'b1100 in one cycle; slots 2 and 3 both = 3.
- Reload and release: load slot 0 = 5, release, then load slot 0 = 9 → no pulse on release; second pulse leaves slot 0 = 9.
- Reset mid-debounce: `pb[0]` held, pulse `rst_n` low at count 2, keep holding → one pulse 7 edges after `rst_n` deasserts; slot 0 = current `holder`.
